// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: synchronized rx, mid-bit sampling, byte strobe or framing error
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BAUD_TICK = CLK_FREQ / BAUD_RATE;
    localparam int HALF_TICK = BAUD_TICK / 2;
    localparam int CNT_W     = (BAUD_TICK > 2) ? $clog2(BAUD_TICK) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_TICK - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICK - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nx;
    logic [2:0]       bit_cnt, bit_cnt_nx;
    logic [7:0]       shift_reg, shift_nx;
    logic [7:0]       rx_data_nx;
    logic             valid_nx, ferr_nx;

    // Both synchronizer flops reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            baud_cnt  <= baud_cnt_nx;
            bit_cnt   <= bit_cnt_nx;
            shift_reg <= shift_nx;
            rx_data   <= rx_data_nx;
            rx_valid  <= valid_nx;
            frame_err <= ferr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        baud_cnt_nx = baud_cnt;
        bit_cnt_nx  = bit_cnt;
        shift_nx    = shift_reg;
        rx_data_nx  = rx_data;
        valid_nx    = 1'b0;
        ferr_nx     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nx    = S_START;
                    baud_cnt_nx = '0;
                end
            end
            S_START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_cnt_nx = '0;
                    bit_cnt_nx  = '0;
                    state_nx    = rx_s ? S_IDLE : S_DATA;
                end else begin
                    baud_cnt_nx = baud_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_nx = '0;
                    shift_nx    = {rx_s, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_nx = S_STOP;
                    end else begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_nx = '0;
                    if (rx_s) begin
                        rx_data_nx = shift_reg;
                        valid_nx   = 1'b1;
                        state_nx   = S_IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = S_BREAK;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt + CNT_W'(1);
                end
            end
            // A held-low line stays here so it reports one error and never restarts a frame.
            S_BREAK: begin
                if (rx_s) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized self-checking bench for uart_rx
module tb_uart_rx;

    localparam int BAUD = 1_000_000 / 100_000;
    localparam int HALF = BAUD / 2;
    localparam int BT   = BAUD * 10;
    localparam int LAT  = 2 + HALF + 9 * BAUD + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] vdata[$];
    int         vcyc[$];
    int         ecyc[$];

    uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            vdata.push_back(rx_data);
            vcyc.push_back(cyc);
        end
        if (frame_err) ecyc.push_back(cyc);
    end

    task chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bt);
        end
        rx = stop;
        #(bt);
    endtask

    int         c0, vb, eb;
    bit         saw_busy;
    logic [7:0] exp_data;
    logic [7:0] rb;
    logic       rstop;
    logic [7:0] c3;

    initial begin
        // reset values
        idle(3);
        @(negedge clk);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_rx_busy", int'(rx_busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);

        // single frame with latency
        vb = vdata.size(); eb = ecyc.size();
        @(posedge clk); #1;
        c0 = cyc;
        send_frame(8'hA5, 1'b1, BT);
        idle(20);
        chk("a5_count", vdata.size() - vb, 1);
        if (vdata.size() > vb) begin
            chk("a5_data", int'(vdata[vb]), 8'hA5);
            chk("a5_latency", vcyc[vb] - c0, LAT);
        end
        chk("a5_no_err", ecyc.size() - eb, 0);

        // back-to-back frames
        vb = vdata.size(); eb = ecyc.size();
        @(posedge clk); #1;
        send_frame(8'h00, 1'b1, BT);
        send_frame(8'hFF, 1'b1, BT);
        send_frame(8'h3C, 1'b1, BT);
        idle(20);
        chk("b2b_count", vdata.size() - vb, 3);
        if (vdata.size() >= vb + 3) begin
            chk("b2b_data0", int'(vdata[vb]), 8'h00);
            chk("b2b_data1", int'(vdata[vb+1]), 8'hFF);
            chk("b2b_data2", int'(vdata[vb+2]), 8'h3C);
            chk("b2b_gap01", vcyc[vb+1] - vcyc[vb], 10 * BAUD);
            chk("b2b_gap12", vcyc[vb+2] - vcyc[vb+1], 10 * BAUD);
        end
        chk("b2b_no_err", ecyc.size() - eb, 0);

        // short glitch rejected
        vb = vdata.size(); eb = ecyc.size();
        @(posedge clk); #1;
        rx = 1'b0;
        #30;
        rx = 1'b1;
        saw_busy = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (rx_busy) saw_busy = 1'b1;
        end
        chk("glitch_busy_seen", int'(saw_busy), 1);
        chk("glitch_busy_clear", int'(rx_busy), 0);
        chk("glitch_no_valid", vdata.size() - vb, 0);
        chk("glitch_no_err", ecyc.size() - eb, 0);
        chk("glitch_data_held", int'(rx_data), 8'h3C);

        // framing error followed by a long break
        vb = vdata.size(); eb = ecyc.size();
        @(posedge clk); #1;
        send_frame(8'h55, 1'b0, BT);
        #(300 * BAUD);
        @(negedge clk);
        chk("break_busy_held", int'(rx_busy), 1);
        chk("break_one_err", ecyc.size() - eb, 1);
        chk("break_no_valid", vdata.size() - vb, 0);
        chk("break_data_held", int'(rx_data), 8'h3C);
        @(posedge clk); #1;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("break_busy_clear", int'(rx_busy), 0);
        chk("break_still_one_err", ecyc.size() - eb, 1);
        vb = vdata.size();
        @(posedge clk); #1;
        send_frame(8'h81, 1'b1, BT);
        idle(20);
        chk("after_break_count", vdata.size() - vb, 1);
        chk("after_break_data", int'(rx_data), 8'h81);

        // reset in the middle of data bit 4
        vb = vdata.size(); eb = ecyc.size();
        c3 = 8'hC3;
        @(posedge clk); #1;
        rx = 1'b0;
        #(BT);
        for (int i = 0; i < 4; i++) begin
            rx = c3[i];
            #(BT);
        end
        rx = c3[4];
        #(BT / 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rx_data", int'(rx_data), 0);
        chk("midrst_rx_valid", int'(rx_valid), 0);
        chk("midrst_frame_err", int'(frame_err), 0);
        chk("midrst_rx_busy", int'(rx_busy), 0);
        #(BT / 2);
        for (int i = 5; i < 8; i++) begin
            rx = c3[i];
            #(BT);
        end
        rx = 1'b1;
        #(BT);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(10);
        chk("midrst_no_valid", vdata.size() - vb, 0);
        chk("midrst_no_err", ecyc.size() - eb, 0);
        @(posedge clk); #1;
        send_frame(8'h7E, 1'b1, BT);
        idle(20);
        chk("post_rst_count", vdata.size() - vb, 1);
        chk("post_rst_data", int'(rx_data), 8'h7E);

        // slow transmitter, 10.4 clk per bit
        vb = vdata.size(); eb = ecyc.size();
        @(posedge clk); #1;
        send_frame(8'h96, 1'b1, 104);
        idle(20);
        chk("slow_count", vdata.size() - vb, 1);
        chk("slow_data", int'(rx_data), 8'h96);
        chk("slow_no_err", ecyc.size() - eb, 0);

        // random frames against the reference model
        exp_data = 8'h96;
        for (int k = 0; k < 12; k++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 3) != 0);
            vb = vdata.size(); eb = ecyc.size();
            @(posedge clk); #1;
            send_frame(rb, rstop, BT);
            if (!rstop) begin
                #(BT * $urandom_range(1, 5));
                rx = 1'b1;
            end
            idle(15 + $urandom_range(0, 30));
            if (rstop) exp_data = rb;
            chk($sformatf("rand%0d_valid", k), vdata.size() - vb, rstop ? 1 : 0);
            chk($sformatf("rand%0d_err", k), ecyc.size() - eb, rstop ? 0 : 1);
            chk($sformatf("rand%0d_data", k), int'(rx_data), int'(exp_data));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the companion to the team's uart_tx.
- Oversamples the asynchronous serial line rx with the system clock.
- Validates the start bit at mid-bit, then samples 8 data bits LSB-first at bit centres and checks the stop bit.
- Delivers each byte with a one-cycle valid strobe, or flags a framing error.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 9600, serial bit rate; BAUD_TICK = CLK_FREQ/BAUD_RATE clocks per bit (integer division), HALF_TICK = BAUD_TICK/2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
rx  input  1  serial line, asynchronous to clk, idle high
rx_data  output  8  last correctly framed byte; holds until next good frame
rx_valid  output  1  one-cycle pulse: rx_data updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset, asynchronous: state IDLE; rx_data=8'h00; rx_valid=0; frame_err=0; rx_busy=0; counters=0.
- rx passes through a 2-FF synchronizer; both flops reset to 1, so no false start after reset. All decisions use the synchronized value rx_s, which lags rx by 2 clk.
- baud_cnt width is at least $clog2(BAUD_TICK). bit_cnt is 3 bits. shift_reg is 8 bits.
- Default every cycle: rx_valid=0 and frame_err=0 (strobes only).
- IDLE:
  - rx_busy=0.
  - On rx_s==0: go to START, baud_cnt=0, rx_busy=1 from the next cycle.
- START:
  - Count to baud_cnt==HALF_TICK-1, then sample rx_s.
  - If rx_s==0: go to DATA, baud_cnt=0, bit_cnt=0.
  - If rx_s==1 (glitch): go to IDLE; no strobe, rx_data unchanged.
- DATA:
  - At baud_cnt==BAUD_TICK-1: shift_reg <= {rx_s, shift_reg[7:1]} (LSB first), baud_cnt=0.
  - If bit_cnt==7: go to STOP. Otherwise bit_cnt+1.
  - Otherwise baud_cnt+1.
- STOP:
  - At baud_cnt==BAUD_TICK-1, sample rx_s.
  - If rx_s==1: rx_data<=shift_reg, rx_valid=1, go to IDLE.
  - If rx_s==0: frame_err=1, rx_data unchanged, go to BREAK.
- BREAK:
  - rx_busy=1.
  - Wait for rx_s==1, then go to IDLE. A held-low line/break produces exactly one frame_err and never re-triggers a start.
- Sampling points, with the falling edge of rx_s at cycle 0:
  - start check at cycle HALF_TICK
  - data bit k at HALF_TICK + (k+1)*BAUD_TICK
  - stop at HALF_TICK + 9*BAUD_TICK
  - rx_valid/frame_err asserted the cycle after the stop sample, i.e. mid-stop-bit.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge arriving at the end of the stop bit is caught with no lost byte.
- Line noise during DATA is not filtered; single-sample per bit.
- Reset mid-frame: immediate return to the reset values; no strobe; partial byte discarded.
- Unused state encodings: go to IDLE.

Test Plan:
(CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> BAUD_TICK=10, HALF_TICK=5)
- Send 8'hA5, 8N1, 10 clk/bit -> exactly one rx_valid pulse ~95 clk after rx falls, rx_data=8'hA5, frame_err never high.
- Back-to-back 8'h00, 8'hFF, 8'h3C with no idle gap -> three rx_valid pulses spaced 100 clk, data in order, no errors.
- 3-clk low glitch on idle rx -> rx_busy high then low within ~8 clk, no rx_valid, no frame_err, rx_data unchanged.
- Send 8'h55 with stop bit forced low, then hold rx low 300 clk, then release -> exactly one frame_err pulse, rx_data keeps previous value, rx_busy stays high until rx_s==1, then next 8'h81 frame received correctly.
- Assert rst during data bit 4 of 8'hC3 -> all outputs at reset values next cycle, no strobe. After release, a fresh 8'h7E is received correctly.
- Baud mismatch: transmitter at 10.4 clk/bit sending 8'h96 -> still received as 8'h96, since centre sampling tolerates ±4%.
